mux_scan_sequencer: RTL and testbench

Scan controller paired with the 8:1 channel mux. It drives the mux select `S` through channels 0 to 7, waits a programmable settle time on each channel, and samples the mux output `f`. It then presents the eight samples as one parallel byte on a valid/ready output port. It sits directly around the mux: upstream of it as the select source, and downstream of it as the consumer of `f`.

---
 rtl/mux_scan_sequencer.sv | 140 ++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// Scan controller for the 8:1 channel mux: steps S through channels 0..7, samples f after
// SETTLE_CYCLES on each channel and offers the byte on a valid/ready port. Define SCAN_PARITY_EN for `parity`.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] S,
  input  logic       f,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
`ifdef SCAN_PARITY_EN
  output logic       busy,
  output logic       parity
`else
  output logic       busy
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam bit         ZERO_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [3:0] SETTLE_LAST = ZERO_SETTLE ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam state_t     CH_FIRST    = ZERO_SETTLE ? ST_SAMPLE : ST_SETTLE;

  state_t     state_q, state_d;
  logic [2:0] s_q, s_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] cap_q, cap_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
`ifdef SCAN_PARITY_EN
  logic       parity_q, parity_d;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef SCAN_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = CH_FIRST;
          s_d     = '0;
          cnt_d   = '0;
          cap_d   = '0;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (s_q != 3'd7) begin
          for (int unsigned k = 0; k < 7; k++) begin
            if (s_q == 3'(k)) begin
              cap_d[k] = f;
            end
          end
          s_d     = s_q + 3'd1;
          cnt_d   = '0;
          state_d = CH_FIRST;
        end else begin
          // Channel 7 bypasses the capture register and lands directly in data.
          data_d  = {f, cap_q};
          valid_d = 1'b1;
          state_d = ST_DONE;
`ifdef SCAN_PARITY_EN
          parity_d = ^{f, cap_q};
`endif
        end
      end

      ST_DONE: begin
        if (ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef SCAN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign S     = s_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;
`ifdef SCAN_PARITY_EN
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: three instances (SETTLE_CYCLES = 1, 0, 3), each with f
// modelled as a per-channel pattern indexed by S, plus an optional glitch.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a [3];
  logic       ready_a [3];
  logic       f_a     [3];
  logic       valid_a [3];
  logic       busy_a  [3];
  logic       glitch_a[3];
  logic [2:0] s_a     [3];
  logic [7:0] data_a  [3];
  logic [7:0] pat_a   [3];
`ifdef SCAN_PARITY_EN
  logic       par_a   [3];
`endif

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start_a[0]), .S(s_a[0]), .f(f_a[0]),
    .data(data_a[0]), .valid(valid_a[0]), .ready(ready_a[0]), .busy(busy_a[0])
`ifdef SCAN_PARITY_EN
    , .parity(par_a[0])
`endif
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .start(start_a[1]), .S(s_a[1]), .f(f_a[1]),
    .data(data_a[1]), .valid(valid_a[1]), .ready(ready_a[1]), .busy(busy_a[1])
`ifdef SCAN_PARITY_EN
    , .parity(par_a[1])
`endif
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(3)) u_dut_s3 (
    .clk(clk), .rst(rst), .start(start_a[2]), .S(s_a[2]), .f(f_a[2]),
    .data(data_a[2]), .valid(valid_a[2]), .ready(ready_a[2]), .busy(busy_a[2])
`ifdef SCAN_PARITY_EN
    , .parity(par_a[2])
`endif
  );

  for (genvar g = 0; g < 3; g++) begin : g_fmux
    assign f_a[g] = pat_a[g][s_a[g]] ^ glitch_a[g];
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         dut;
    logic [7:0] data;
    int         lat;
    bit         par;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int         dut;
    logic [7:0] pat;
    bit         glitch;
    logic [7:0] exp_data;
    int         exp_lat;
    bit         exp_par;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_check(input int d);
    chk("rst_S", 32'(s_a[d]), 0);
    chk("rst_data", 32'(data_a[d]), 0);
    chk("rst_valid", 32'(valid_a[d]), 0);
    chk("rst_busy", 32'(busy_a[d]), 0);
`ifdef SCAN_PARITY_EN
    chk("rst_parity", 32'(par_a[d]), 0);
`endif
  endtask

  // Glitch window assumes a 4-cycle channel period, so it is only enabled for SETTLE_CYCLES=3.
  task automatic do_scan(input int d, input logic [7:0] pat, input bit glitch, input logic rdy,
                         input bit keep_start, input logic [7:0] exp_data, input int exp_lat,
                         input bit exp_par);
    sb_t e;
    int  c;
    sb_q.push_back('{d, exp_data, exp_lat, exp_par});
    @(negedge clk);
    pat_a[d]   = pat;
    ready_a[d] = rdy;
    start_a[d] = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_start) start_a[d] = 1'b0;
    chk("S_after_start", 32'(s_a[d]), 0);
    chk("busy_after_start", 32'(busy_a[d]), 1);
    c = 0;
    glitch_a[d] = glitch && (c % 4 < 2);
    while (!valid_a[d] && c < 300) begin
      @(posedge clk);
      #1;
      c++;
      glitch_a[d] = glitch && (c % 4 < 2);
    end
    glitch_a[d] = 1'b0;
    e = sb_q.pop_front();
    chk("valid_seen", 32'(valid_a[d]), 1);
    chk("latency", 32'(c), 32'(e.lat));
    chk("data", 32'(data_a[d]), 32'(e.data));
    chk("S_in_done", 32'(s_a[d]), 7);
`ifdef SCAN_PARITY_EN
    chk("parity", 32'(par_a[d]), 32'(e.par));
`endif
  endtask

  task automatic handshake_check(input int d, input logic [7:0] exp_data);
    @(posedge clk);
    #1;
    chk("valid_after_hs", 32'(valid_a[d]), 0);
    chk("busy_after_hs", 32'(busy_a[d]), 0);
    chk("data_held_hs", 32'(data_a[d]), 32'(exp_data));
    chk("S_held_hs", 32'(s_a[d]), 7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 8'h00, 1'b0, 8'h00, 16, 1'b0};
    tbl[1] = '{1, 8'h80, 1'b0, 8'h80, 8,  1'b1};
    tbl[2] = '{2, 8'hA5, 1'b1, 8'hA5, 32, 1'b0};
    tbl[3] = '{0, 8'h4D, 1'b0, 8'h4D, 16, 1'b0};
    tbl[4] = '{1, 8'h3C, 1'b0, 8'h3C, 8,  1'b0};
    tbl[5] = '{2, 8'h01, 1'b1, 8'h01, 32, 1'b1};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_a[i]  = 1'b0;
      ready_a[i]  = 1'b1;
      glitch_a[i] = 1'b0;
      pat_a[i]    = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) reset_check(i);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_scan(tbl[i].dut, tbl[i].pat, tbl[i].glitch, 1'b1, 1'b0,
              tbl[i].exp_data, tbl[i].exp_lat, tbl[i].exp_par);
      handshake_check(tbl[i].dut, tbl[i].exp_data);
    end

    // Reset during the channel-3 settle cycle, then a clean all-ones scan.
    @(negedge clk);
    pat_a[0]   = 8'hFF;
    start_a[0] = 1'b1;
    @(posedge clk);
    #1;
    start_a[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("S_before_midrst", 32'(s_a[0]), 3);
    rst = 1'b1;
    #1;
    reset_check(0);
    @(negedge clk);
    rst = 1'b0;
    do_scan(0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 16, 1'b0);
    handshake_check(0, 8'hFF);

    // Backpressure: hold ready low in DONE while f toggles.
    do_scan(0, 8'h96, 1'b0, 1'b0, 1'b0, 8'h96, 16, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pat_a[0] = ~pat_a[0];
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(valid_a[0]), 1);
      chk("bp_data", 32'(data_a[0]), 32'h96);
      chk("bp_S", 32'(s_a[0]), 7);
    end
    @(negedge clk);
    ready_a[0] = 1'b1;
    handshake_check(0, 8'h96);

    // start held through the scan and the handshake edge: exactly one scan.
    do_scan(0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 16, 1'b0);
    @(posedge clk);
    #1;
    start_a[0] = 1'b0;
    chk("hs_start_valid", 32'(valid_a[0]), 0);
    chk("hs_start_busy", 32'(busy_a[0]), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("idle_busy", 32'(busy_a[0]), 0);
      chk("idle_S", 32'(s_a[0]), 7);
    end
    do_scan(0, 8'hC3, 1'b0, 1'b1, 1'b0, 8'hC3, 16, 1'b0);
    handshake_check(0, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
